l1_fwd_responder: RTL and testbench

L1_FWD_RESPONDER -- requirements
Module: l1_fwd_responder

---
 rtl/l1_fwd_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_l1_fwd_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_fwd_responder.sv
// rtl/l1_fwd_responder.sv - L1 forward-request responder
//
// Purpose:
//   Accepts a coherence forward request (LOAD_FWD / STORE_FWD / INV_FWD) on
//   noc2, queries the local line through the lookup port, and answers on noc3
//   with the matching *_FWDACK message. The line data is returned only when
//   the line is dirty and the request is not an invalidation. Any other
//   message arriving on noc2 is swallowed (header plus payload) silently.
//   Only one request is handled at a time.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   chipid, coreid_x, coreid_y    own tile identity (goes into the SRC flit)
//   noc2_valid_in/data_in/ready_in    request flit input
//   noc3_valid_out/data_out/ready_out response flit output
//   lookup_valid, lookup_addr     local line query (held until ack/timeout)
//   lookup_ack, lookup_dirty, lookup_data  query result
//   err_timeout                   sticky: a lookup was never acknowledged
//
// Parameter:
//   LOOKUP_TIMEOUT  cycles to wait for lookup_ack (1..255)

module l1_fwd_responder #(
   parameter int LOOKUP_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [13:0]  chipid,
   input  logic [7:0]   coreid_x,
   input  logic [7:0]   coreid_y,
   input  logic         noc2_valid_in,
   input  logic [63:0]  noc2_data_in,
   output logic         noc2_ready_in,
   output logic         noc3_valid_out,
   output logic [63:0]  noc3_data_out,
   input  logic         noc3_ready_out,
   output logic         lookup_valid,
   output logic [39:0]  lookup_addr,
   input  logic         lookup_ack,
   input  logic         lookup_dirty,
   input  logic [127:0] lookup_data,
   output logic         err_timeout
);

   localparam logic [7:0] MSG_LOAD_FWD  = 8'd16;
   localparam logic [7:0] MSG_STORE_FWD = 8'd17;
   localparam logic [7:0] MSG_INV_FWD   = 8'd18;
   localparam logic [7:0] TIMEOUT_CNT   = 8'(LOOKUP_TIMEOUT);

   typedef enum logic [3:0] {
      IDLE,
      RX_ADDR,
      RX_SRC,
      LOOKUP,
      TX_HDR,
      TX_ADDR,
      TX_SRC,
      TX_D0,
      TX_D1,
      DRAIN
   } state_t;

   state_t         state;

   // request context
   logic [7:0]     req_type;
   logic [7:0]     req_mshrid;
   logic [3:0]     req_fbits;
   logic [5:0]     req_opts;
   logic [39:0]    req_addr;
   logic [13:0]    src_chipid;
   logic [7:0]     src_x;
   logic [7:0]     src_y;

   // lookup result
   logic           line_dirty;
   logic [127:0]   line_data;

   logic [7:0]     wait_cnt;
   logic [7:0]     drain_cnt;

   // header fields of the incoming flit
   logic [7:0]     hdr_len;
   logic [7:0]     hdr_type;
   logic           hdr_is_fwd;

   logic           noc2_fire;
   logic           noc3_fire;
   logic           with_data;
   logic [63:0]    resp_hdr;

   assign noc2_fire  = noc2_valid_in & noc2_ready_in;
   assign noc3_fire  = noc3_valid_out & noc3_ready_out;

   assign hdr_len    = noc2_data_in[29:22];
   assign hdr_type   = noc2_data_in[21:14];
   assign hdr_is_fwd = (hdr_type >= MSG_LOAD_FWD) && (hdr_type <= MSG_INV_FWD)
                       && (hdr_len == 8'd2);

   // an invalidation never returns data even when the line was dirty
   assign with_data  = line_dirty && (req_type != MSG_INV_FWD);

   // *_FWDACK codes sit exactly 3 above their *_FWD request codes
   assign resp_hdr   = {src_chipid, src_x, src_y, req_fbits,
                        (with_data ? 8'd4 : 8'd2),
                        req_type + 8'd3, req_mshrid, req_opts};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         req_type       <= '0;
         req_mshrid     <= '0;
         req_fbits      <= '0;
         req_opts       <= '0;
         req_addr       <= '0;
         src_chipid     <= '0;
         src_x          <= '0;
         src_y          <= '0;
         line_dirty     <= 1'b0;
         line_data      <= '0;
         wait_cnt       <= '0;
         drain_cnt      <= '0;
         noc2_ready_in  <= 1'b0;
         noc3_valid_out <= 1'b0;
         noc3_data_out  <= '0;
         lookup_valid   <= 1'b0;
         lookup_addr    <= '0;
         err_timeout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // ready comes up on the first clock after reset release
               noc2_ready_in <= 1'b1;
               if (noc2_fire) begin
                  req_type   <= hdr_type;
                  req_mshrid <= noc2_data_in[13:6];
                  req_fbits  <= noc2_data_in[33:30];
                  req_opts   <= noc2_data_in[5:0];
                  if (hdr_is_fwd) begin
                     state <= RX_ADDR;
                  end else if (hdr_len != 8'd0) begin
                     drain_cnt <= hdr_len;
                     state     <= DRAIN;
                  end
               end
            end

            RX_ADDR: begin
               if (noc2_fire) begin
                  req_addr <= noc2_data_in[39:0];
                  state    <= RX_SRC;
               end
            end

            RX_SRC: begin
               if (noc2_fire) begin
                  src_chipid    <= noc2_data_in[63:50];
                  src_x         <= noc2_data_in[49:42];
                  src_y         <= noc2_data_in[41:34];
                  noc2_ready_in <= 1'b0;
                  lookup_valid  <= 1'b1;
                  lookup_addr   <= req_addr;
                  wait_cnt      <= '0;
                  state         <= LOOKUP;
               end
            end

            LOOKUP: begin
               // an ack in the same cycle as the timeout takes priority
               if (lookup_ack) begin
                  line_dirty   <= lookup_dirty;
                  line_data    <= lookup_data;
                  lookup_valid <= 1'b0;
                  lookup_addr  <= '0;
                  state        <= TX_HDR;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  line_dirty   <= 1'b0;
                  err_timeout  <= 1'b1;
                  lookup_valid <= 1'b0;
                  lookup_addr  <= '0;
                  state        <= TX_HDR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            TX_HDR: begin
               // first cycle builds the header from the latched dirty bit,
               // afterwards hold it until the handshake
               if (!noc3_valid_out) begin
                  noc3_valid_out <= 1'b1;
                  noc3_data_out  <= resp_hdr;
               end else if (noc3_ready_out) begin
                  noc3_data_out <= {24'b0, req_addr};
                  state         <= TX_ADDR;
               end
            end

            TX_ADDR: begin
               if (noc3_fire) begin
                  noc3_data_out <= {chipid, coreid_x, coreid_y, 34'b0};
                  state         <= TX_SRC;
               end
            end

            TX_SRC: begin
               if (noc3_fire) begin
                  if (with_data) begin
                     noc3_data_out <= line_data[63:0];
                     state         <= TX_D0;
                  end else begin
                     noc3_valid_out <= 1'b0;
                     noc3_data_out  <= '0;
                     noc2_ready_in  <= 1'b1;
                     state          <= IDLE;
                  end
               end
            end

            TX_D0: begin
               if (noc3_fire) begin
                  noc3_data_out <= line_data[127:64];
                  state         <= TX_D1;
               end
            end

            TX_D1: begin
               if (noc3_fire) begin
                  noc3_valid_out <= 1'b0;
                  noc3_data_out  <= '0;
                  noc2_ready_in  <= 1'b1;
                  state          <= IDLE;
               end
            end

            DRAIN: begin
               if (noc2_fire) begin
                  if (drain_cnt == 8'd1) begin
                     drain_cnt <= '0;
                     state     <= IDLE;
                  end else begin
                     drain_cnt <= drain_cnt - 8'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_fwd_responder.sv
// tb/tb_l1_fwd_responder.sv - self-checking bench for l1_fwd_responder

module tb_l1_fwd_responder;

   localparam int T = 4;
   localparam logic [13:0] OWN_CHIP = 14'h2A5;
   localparam logic [7:0]  OWN_X    = 8'h07;
   localparam logic [7:0]  OWN_Y    = 8'h0B;

   logic         clk = 1'b0;
   logic         rst;
   logic         noc2_valid_in;
   logic [63:0]  noc2_data_in;
   logic         noc2_ready_in;
   logic         noc3_valid_out;
   logic [63:0]  noc3_data_out;
   logic         noc3_ready_out;
   logic         lookup_valid;
   logic [39:0]  lookup_addr;
   logic         lookup_ack;
   logic         lookup_dirty;
   logic [127:0] lookup_data;
   logic         err_timeout;

   l1_fwd_responder #(.LOOKUP_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .chipid(OWN_CHIP), .coreid_x(OWN_X), .coreid_y(OWN_Y),
      .noc2_valid_in(noc2_valid_in), .noc2_data_in(noc2_data_in), .noc2_ready_in(noc2_ready_in),
      .noc3_valid_out(noc3_valid_out), .noc3_data_out(noc3_data_out), .noc3_ready_out(noc3_ready_out),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_ack(lookup_ack),
      .lookup_dirty(lookup_dirty), .lookup_data(lookup_data), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // environment controls
   int           ack_delay = -1;
   logic         lk_dirty = 1'b0;
   logic [127:0] lk_data = '0;
   int           lk_cnt = 0;
   int           lk_cycles = 0;
   logic [39:0]  lk_addr_seen = '0;
   int           ack_cyc = 0;
   int           first_valid_cyc = -1;
   int           hold_idx = -1;
   bit           stall_d0 = 0;
   int           stall_n = 0;
   logic [63:0]  stall_exp = '0;
   bit           rand_mode = 0;
   logic         model_err = 1'b0;

   logic [63:0]  rxq[$];
   logic [63:0]  exq[$];

   typedef struct {
      logic [7:0]   typ;
      logic [7:0]   len;
      logic [7:0]   mshrid;
      logic [13:0]  sc;
      logic [7:0]   sx;
      logic [7:0]   sy;
      logic [39:0]  addr;
      logic         dirty;
      logic [127:0] data;
      int           delay;
      logic [7:0]   e_type;
      logic [7:0]   e_len;
      int           e_n;
      logic         e_err;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      $display("FAIL %s: wait bound expired, got timeout expected event", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mk_hdr(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] fb, input logic [7:0] len, input logic [7:0] typ,
                                          input logic [7:0] msh, input logic [5:0] opt);
      return {c, x, y, fb, len, typ, msh, opt};
   endfunction

   // lookup responder: acks on the ack_delay-th LOOKUP cycle (0-based), garbage otherwise
   initial begin
      lookup_ack = 0; lookup_dirty = 0; lookup_data = '0;
      forever begin
         @(posedge clk); #2;
         lookup_ack = 0;
         if (lookup_valid) begin
            if (lk_cnt == 0) lk_addr_seen = lookup_addr;
            if (ack_delay >= 0 && lk_cnt == ack_delay) begin
               lookup_ack = 1; lookup_dirty = lk_dirty; lookup_data = lk_data; ack_cyc = cyc;
            end else begin
               lookup_dirty = 1'($urandom);
               lookup_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            lk_cnt++;
            lk_cycles = lk_cnt;
         end else begin
            lk_cnt = 0;
         end
      end
   end

   // noc3 ready driver
   initial begin
      noc3_ready_out = 0;
      forever begin
         @(posedge clk); #1;
         if (hold_idx >= 0 && rxq.size() == hold_idx) begin
            noc3_ready_out = 0;
         end else if (stall_d0 && rxq.size() == 3 && noc3_valid_out && stall_n < 5) begin
            noc3_ready_out = 0;
            stall_n++;
            chk($sformatf("d0_hold_cycle%0d", stall_n), {noc3_valid_out, noc3_data_out}, {1'b1, stall_exp});
         end else begin
            noc3_ready_out = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // noc3 collector
   initial begin
      forever begin
         @(negedge clk);
         if (noc3_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (noc3_valid_out && noc3_ready_out) rxq.push_back(noc3_data_out);
      end
   end

   task automatic send_flit(input logic [63:0] f, input string name);
      if (rand_mode) repeat ($urandom_range(0, 2)) step();
      noc2_valid_in = 1; noc2_data_in = f;
      for (int w = 0; ; w++) begin
         if (noc2_ready_in) begin step(); break; end
         if (w >= 500) begin bound_fail(name); break; end
         step();
      end
      noc2_valid_in = 0; noc2_data_in = '0;
   endtask

   task automatic send_request(input logic [7:0] typ, input logic [7:0] len, input logic [7:0] msh,
                               input logic [3:0] fb, input logic [5:0] opt, input logic [13:0] sc,
                               input logic [7:0] sx, input logic [7:0] sy, input logic [39:0] addr,
                               input string tag);
      bit fwd;
      fwd = (typ >= 8'd16 && typ <= 8'd18 && len == 8'd2);
      send_flit(mk_hdr(OWN_CHIP, OWN_X, OWN_Y, fb, len, typ, msh, opt), {tag, ".hdr_accept"});
      if (fwd) begin
         send_flit({24'($urandom), addr}, {tag, ".addr_accept"});
         send_flit({sc, sx, sy, 34'($urandom)}, {tag, ".src_accept"});
      end else begin
         for (int i = 0; i < int'(len); i++) send_flit({$urandom, $urandom}, {tag, ".payload_accept"});
      end
   endtask

   // Reference: the response a request must produce, from the message rules alone
   task automatic run_req(input logic [7:0] typ, input logic [7:0] len, input logic [7:0] msh,
                          input logic [3:0] fb, input logic [5:0] opt, input logic [13:0] sc,
                          input logic [7:0] sx, input logic [7:0] sy, input logic [39:0] addr,
                          input logic dirty, input logic [127:0] data, input int delay,
                          input string tag);
      bit fwd, acked, wd;
      lk_dirty = dirty; lk_data = data; ack_delay = delay; lk_cycles = 0;
      rxq.delete(); exq.delete();
      fwd   = (typ >= 8'd16 && typ <= 8'd18 && len == 8'd2);
      acked = (delay >= 0) && (delay <= T);
      wd    = acked && dirty && (typ != 8'd18);
      if (fwd) begin
         exq.push_back(mk_hdr(sc, sx, sy, fb, wd ? 8'd4 : 8'd2, typ + 8'd3, msh, opt));
         exq.push_back({24'h0, addr});
         exq.push_back({OWN_CHIP, OWN_X, OWN_Y, 34'h0});
         if (wd) begin
            exq.push_back(data[63:0]);
            exq.push_back(data[127:64]);
         end
         if (!acked) model_err = 1'b1;
      end
      send_request(typ, len, msh, fb, opt, sc, sx, sy, addr, tag);
      for (int w = 0; w < 400 && rxq.size() < exq.size(); w++) step();
      repeat (6) step();
      chk({tag, ".flit_count"}, 128'(rxq.size()), 128'(exq.size()));
      for (int i = 0; i < exq.size() && i < rxq.size(); i++)
         chk($sformatf("%s.flit%0d", tag, i), rxq[i], exq[i]);
      if (fwd) begin
         chk({tag, ".lookup_cycles"}, 128'(lk_cycles), 128'(acked ? delay + 1 : T + 1));
         chk({tag, ".lookup_addr"}, lk_addr_seen, addr);
      end
      chk({tag, ".err_timeout"}, err_timeout, model_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1; noc2_valid_in = 0; noc2_data_in = '0;

      tbl[0] = '{8'd17, 8'd2, 8'd5,    14'd3,   8'd1,   8'd2,   40'h12_3456_7880, 1'b1,
                 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB, 0, 8'd20, 8'd4, 5, 1'b0};
      tbl[1] = '{8'd18, 8'd2, 8'd9,    14'h100, 8'h44,  8'h55,  40'hAB_CDEF_0000, 1'b1,
                 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, 8'd21, 8'd2, 3, 1'b0};
      tbl[2] = '{8'd16, 8'd2, 8'h7F,   14'h3FFF, 8'hFF, 8'h00,  40'h00_0000_0040, 1'b0,
                 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002, 2, 8'd19, 8'd2, 3, 1'b0};
      tbl[3] = '{8'd16, 8'd2, 8'h80,   14'h001, 8'h10,  8'h20,  40'hFF_FFFF_FFC0, 1'b1,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 8'd19, 8'd4, 5, 1'b0};
      tbl[4] = '{8'd17, 8'd2, 8'hFF,   14'h155, 8'h0A,  8'h0B,  40'h55_AAAA_5540, 1'b1,
                 128'h9999_8888_7777_6666_5555_4444_3333_2222, T, 8'd20, 8'd4, 5, 1'b0};
      tbl[5] = '{8'd7,  8'd3, 8'd1,    14'd0,   8'd0,   8'd0,   40'h0, 1'b0, 128'h0, 0, 8'd0, 8'd0, 0, 1'b0};
      tbl[6] = '{8'd16, 8'd3, 8'd2,    14'd0,   8'd0,   8'd0,   40'h0, 1'b0, 128'h0, 0, 8'd0, 8'd0, 0, 1'b0};
      tbl[7] = '{8'd19, 8'd0, 8'd3,    14'd0,   8'd0,   8'd0,   40'h0, 1'b0, 128'h0, 0, 8'd0, 8'd0, 0, 1'b0};
      tbl[8] = '{8'd16, 8'd2, 8'h11,   14'h0AB, 8'h03,  8'h04,  40'h01_0203_0400, 1'b1,
                 128'h4242_4242_4242_4242_2424_2424_2424_2424, -1, 8'd19, 8'd2, 3, 1'b1};

      repeat (3) step();
      chk("reset.noc2_ready_in",  noc2_ready_in, 0);
      chk("reset.noc3_valid_out", noc3_valid_out, 0);
      chk("reset.noc3_data_out",  noc3_data_out, 0);
      chk("reset.lookup_valid",   lookup_valid, 0);
      chk("reset.lookup_addr",    lookup_addr, 0);
      chk("reset.err_timeout",    err_timeout, 0);
      rst = 0;
      repeat (2) step();

      for (int i = 0; i < 9; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_req(tbl[i].typ, tbl[i].len, tbl[i].mshrid, 4'h3, 6'h15, tbl[i].sc, tbl[i].sx, tbl[i].sy,
                 tbl[i].addr, tbl[i].dirty, tbl[i].data, tbl[i].delay, tag);
         chk({tag, ".count_tbl"}, 128'(rxq.size()), 128'(tbl[i].e_n));
         if (tbl[i].e_n > 0 && rxq.size() > 0) begin
            chk({tag, ".type_tbl"}, rxq[0][21:14], tbl[i].e_type);
            chk({tag, ".len_tbl"},  rxq[0][29:22], tbl[i].e_len);
            chk({tag, ".mshrid_tbl"}, rxq[0][13:6], tbl[i].mshrid);
            chk({tag, ".dst_tbl"}, rxq[0][63:34], {tbl[i].sc, tbl[i].sx, tbl[i].sy});
         end
         chk({tag, ".err_tbl"}, err_timeout, tbl[i].e_err);
      end

      // response header appears in the 2nd cycle after the ack cycle
      first_valid_cyc = -1;
      run_req(8'd16, 8'd2, 8'd6, 4'h1, 6'h2, 14'h12, 8'h3, 8'h4, 40'h00_1000_0000, 1'b0, '0, 0, "latency");
      chk("latency.hdr_after_ack", 128'(first_valid_cyc - ack_cyc), 128'(2));

      // backpressure on the first data flit for 5 cycles
      stall_d0 = 1; stall_n = 0;
      stall_exp = 64'h0F0E_0D0C_0B0A_0908;
      run_req(8'd17, 8'd2, 8'd7, 4'h2, 6'h3, 14'h21, 8'h5, 8'h6, 40'h00_2000_0040, 1'b1,
              128'h1716_1514_1312_1110_0F0E_0D0C_0B0A_0908, 1, "stall");
      stall_d0 = 0;
      chk("stall.cycles", 128'(stall_n), 128'(5));

      // reset while the ADDR flit is being presented
      hold_idx = 1; lk_dirty = 1; lk_data = {4{32'h5A5A_A5A5}}; ack_delay = 0; rxq.delete();
      send_request(8'd17, 8'd2, 8'd8, 4'h4, 6'h4, 14'h33, 8'h7, 8'h8, 40'h00_3000_0080, "rst_mid");
      begin
         int w;
         for (w = 0; w < 200 && !(rxq.size() == 1 && noc3_valid_out); w++) step();
         if (w >= 200) bound_fail("rst_mid.reach_tx_addr");
      end
      step(); step();
      #2 rst = 1;
      #1;
      chk("rst_mid.noc2_ready_in",  noc2_ready_in, 0);
      chk("rst_mid.noc3_valid_out", noc3_valid_out, 0);
      chk("rst_mid.noc3_data_out",  noc3_data_out, 0);
      chk("rst_mid.lookup_valid",   lookup_valid, 0);
      chk("rst_mid.lookup_addr",    lookup_addr, 0);
      chk("rst_mid.err_timeout",    err_timeout, 0);
      hold_idx = -1; model_err = 0;
      step(); step();
      rst = 0;
      step();
      run_req(8'd17, 8'd2, 8'd5, 4'h0, 6'h0, 14'd3, 8'd1, 8'd2, 40'h12_3456_7880, 1'b1,
              128'hCCCC_DDDD_EEEE_FFFF_0000_1111_2222_3333, 0, "after_rst");

      // randomized traffic against the reference
      rand_mode = 1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] typ, len;
         int kind;
         kind = $urandom_range(0, 3);
         if (kind < 3) begin
            typ = 8'd16 + 8'($urandom_range(0, 2)); len = 8'd2;
         end else begin
            typ = 8'($urandom); len = 8'($urandom_range(0, 4));
         end
         run_req(typ, len, 8'($urandom), 4'($urandom), 6'($urandom), 14'($urandom), 8'($urandom),
                 8'($urandom), {$urandom, 8'($urandom)}, 1'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 6),
                 $sformatf("rand%0d", n));
      end
      rand_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
